// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first into a configuration flip-flop chain.
// Define CCFF_READBACK_EN to add a recirculating CRC-8 readback check.
module ccff_chain_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int REM_W = $clog2(DATA_W + 1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(DATA_W);
    localparam logic [15:0] LAST = 16'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
`ifdef CCFF_READBACK_EN
        S_VERIFY = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_bit_cnt;
    logic [DATA_W-1:0] r_word;
    logic [REM_W-1:0]  r_rem;
    logic              w_start;
    logic              w_xfer;
    logic              w_last;
    logic              w_load_shift;

    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        word_ready    = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start = 1'b1;
                    w_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                ccff_shift_en = (r_rem != '0);
                ccff_head     = ccff_shift_en & r_word[DATA_W-1];
                // An empty register may always refill; on the last bit of a
                // word, refill only if the chain still wants more bits.
                word_ready = (r_rem == '0) ||
                             ((r_rem == REM_ONE) && (r_bit_cnt < LAST));
                if (ccff_shift_en && (r_bit_cnt == LAST)) begin
`ifdef CCFF_READBACK_EN
                    w_next = S_VERIFY;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef CCFF_READBACK_EN
            S_VERIFY: begin
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                if (r_bit_cnt == LAST) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_xfer       = word_valid & word_ready;
    assign w_last       = ccff_shift_en & (r_bit_cnt == LAST);
    assign w_load_shift = (r_state == S_LOAD) & ccff_shift_en;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_word    <= '0;
            r_rem     <= '0;
        end else begin
            r_state <= w_next;
            if (w_start || w_last) begin
                r_bit_cnt <= '0;
            end else if (ccff_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 16'd1;
            end
            // Leftover low bits of the final word are dropped here.
            if (w_start || (w_load_shift && w_last)) begin
                r_word <= '0;
                r_rem  <= '0;
            end else if (w_xfer) begin
                r_word <= word_data;
                r_rem  <= REM_FULL;
            end else if (w_load_shift) begin
                r_word <= {r_word[DATA_W-2:0], 1'b0};
                r_rem  <= r_rem - REM_ONE;
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [7:0] r_wcrc;
    logic [7:0] r_rcrc;
    logic [7:0] w_rcrc_next;
    logic       r_error;

    function automatic logic [7:0] crc8_step(input logic [7:0] c,
                                             input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign w_rcrc_next = crc8_step(r_rcrc, ccff_tail);
    assign error       = r_error;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_wcrc  <= '0;
            r_rcrc  <= '0;
            r_error <= 1'b0;
        end else if (w_start) begin
            r_wcrc  <= '0;
            r_rcrc  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_load_shift) begin
                r_wcrc <= crc8_step(r_wcrc, ccff_head);
            end
            if (r_state == S_VERIFY) begin
                r_rcrc <= w_rcrc_next;
                if (w_last) begin
                    r_error <= (w_rcrc_next != r_wcrc);
                end
            end
        end
    end
`else
    logic w_tail_unused;
    assign w_tail_unused = ccff_tail;
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 20-bit chain model.
// Define CCFF_READBACK_EN to also exercise the readback path.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    localparam int DW = 8;
    localparam int CL = 20;
`ifdef CCFF_READBACK_EN
    localparam int LAT = 2 * CL + 2;
`else
    localparam int LAT = CL + 2;
`endif

    logic          prog_clk = 1'b0;
    logic          prog_reset;
    logic          start;
    logic [DW-1:0] word_data;
    logic          word_valid;
    logic          word_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          error;

    int n_vec = 0;
    int n_err = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.DATA_W(DW), .CHAIN_LEN(CL)) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    // Chain model: head enters bit 0, tail is bit CL-1; optional stuck-at-1 on bit 7.
    logic [CL-1:0] chain = '0;
    logic          stuck7;
    always @(posedge prog_clk) begin
        logic [CL-1:0] n;
        if (ccff_shift_en) begin
            n = {chain[CL-2:0], ccff_head};
            if (stuck7) n[7] = 1'b1;
            chain <= n;
        end
    end
    assign ccff_tail = chain[CL-1];

    // Word source with an optional refusal window before the third word.
    logic [DW-1:0] words [3];
    int            widx;
    int            stall_left;
    int            stall_req;
    logic          src_en;
    logic          src_clr;

    always_comb begin
        word_data  = (widx < 3) ? words[widx] : '0;
        word_valid = src_en && (widx < 3) && !((widx == 2) && (stall_left > 0));
    end

    always @(posedge prog_clk) begin
        if (src_clr) begin
            widx       <= 0;
            stall_left <= stall_req;
        end else begin
            if (word_valid && word_ready) widx <= widx + 1;
            if ((widx == 2) && (stall_left > 0) && word_ready)
                stall_left <= stall_left - 1;
        end
    end

    int            n_hs;
    int            n_bits;
    int            n_done;
    int            n_bubble;
    int            n_headbad;
    logic [CL-1:0] seq;

    always @(negedge prog_clk) begin
        if (src_clr) begin
            n_hs = 0; n_bits = 0; n_done = 0;
            n_bubble = 0; n_headbad = 0; seq = '0;
        end else begin
            if (word_valid && word_ready) n_hs++;
            if (ccff_shift_en && (n_bits < CL)) begin
                seq = {seq[CL-2:0], ccff_head};
                n_bits++;
            end
            if (done) n_done++;
            if (busy && !done && !ccff_shift_en) n_bubble++;
            if (!ccff_shift_en && ccff_head) n_headbad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // Latency is counted in edges from the one capturing start to the one
    // capturing done: done seen after edge c means it is captured at c+1.
    task automatic do_load(input int stall, input bit extra,
                           output int lat, output logic err_start,
                           output logic err_done);
        src_clr   = 1'b1;
        stall_req = stall;
        step();
        src_clr = 1'b0;
        start   = 1'b1;
        src_en  = 1'b1;
        step();
        start     = 1'b0;
        err_start = error;
        err_done  = 1'bx;
        lat       = -1;
        for (int c = 1; c <= 200; c++) begin
            step();
            start = extra && ((c == 3) || (c == 10));
            if (done) begin
                lat      = c + 1;
                err_done = error;
                break;
            end
        end
        start  = 1'b0;
        src_en = 1'b0;
    endtask

    int   lat;
    logic e_st;
    logic e_dn;

    initial begin
        prog_reset = 1'b1;
        start      = 1'b0;
        src_en     = 1'b0;
        src_clr    = 1'b1;
        stall_req  = 0;
        stuck7     = 1'b0;
        words[0]   = 8'hA5;
        words[1]   = 8'h3C;
        words[2]   = 8'hF0;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_shift", 32'(ccff_shift_en), 32'd0);
        chk("rst_head", 32'(ccff_head), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        prog_reset = 1'b0;
        src_clr    = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        do_load(0, 1'b0, lat, e_st, e_dn);
        chk("base_lat", 32'(lat), 32'(LAT));
        chk("base_hs", 32'(n_hs), 32'd3);
        chk("base_seq", 32'(seq), 32'h000A53CF);
        chk("base_bubble", 32'(n_bubble), 32'd1);
        chk("base_headbad", 32'(n_headbad), 32'd0);
        chk("base_err", 32'(e_dn), 32'd0);
        step();
        chk("base_ndone", 32'(n_done), 32'd1);
        chk("base_ready_after", 32'(word_ready), 32'd0);

        do_load(5, 1'b0, lat, e_st, e_dn);
        chk("stall_lat", 32'(lat), 32'(LAT + 5));
        chk("stall_hs", 32'(n_hs), 32'd3);
        chk("stall_seq", 32'(seq), 32'h000A53CF);
        chk("stall_bubble", 32'(n_bubble), 32'd6);
        chk("stall_headbad", 32'(n_headbad), 32'd0);

        do_load(0, 1'b1, lat, e_st, e_dn);
        chk("restart_lat", 32'(lat), 32'(LAT));
        chk("restart_hs", 32'(n_hs), 32'd3);
        chk("restart_seq", 32'(seq), 32'h000A53CF);
        step();
        step();
        chk("restart_idle", 32'(busy), 32'd0);

        src_clr = 1'b1;
        step();
        src_clr = 1'b0;
        start   = 1'b1;
        src_en  = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; (c < 50) && (n_bits < 9); c++) step();
        chk("abort_bits", 32'(n_bits), 32'd9);
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(word_ready), 32'd0);
        chk("abort_shift", 32'(ccff_shift_en), 32'd0);
        step();
        step();
        step();
        chk("abort_ndone", 32'(n_done), 32'd0);
        src_en = 1'b0;

        do_load(0, 1'b0, lat, e_st, e_dn);
        chk("reload_lat", 32'(lat), 32'(LAT));
        chk("reload_hs", 32'(n_hs), 32'd3);
        chk("reload_seq", 32'(seq), 32'h000A53CF);
        chk("reload_err", 32'(e_dn), 32'd0);

`ifdef CCFF_READBACK_EN
        words[0] = 8'hFF;
        words[1] = 8'hF7;
        words[2] = 8'hFF;
        stuck7   = 1'b1;
        do_load(0, 1'b0, lat, e_st, e_dn);
        chk("stuck_lat", 32'(lat), 32'(LAT));
        chk("stuck_seq", 32'(seq), 32'h000FFF7F);
        chk("stuck_err_done", 32'(e_dn), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("stuck_err_hold", 32'(error), 32'd1);
        stuck7   = 1'b0;
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hF0;
        do_load(0, 1'b0, lat, e_st, e_dn);
        chk("clear_err_start", 32'(e_st), 32'd0);
        chk("clear_err_done", 32'(e_dn), 32'd0);
        chk("clear_lat", 32'(lat), 32'(LAT));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
